fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares the write port of one Synchronous_FIFO between NUM_REQ producers.
- Grants a producer a locked burst of up to BURST_LEN beats, then rotates priority.
- Drives the FIFO's we_enb/data_in and honours its full flag, so the FIFO is never written when full.
- Sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/fifo_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, statistics width
// and a clog2 helper usable in parameter expressions.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Never returns less than 1 so that index vectors stay legal for tiny sizes.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle seen by the arbiter. The slave modport is the
// arbiter; the master modport is whoever drives requests and the full flag.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      full;
    logic                      we_enb;
    logic [DATA_W-1:0]         data_in;

    modport master (
        output req, req_data, full,
        input  gnt, we_enb, data_in
    );

    modport slave (
        input  req, req_data, full,
        output gnt, we_enb, data_in
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational circular priority picker: first set req bit at or after ptr,
// wrapping modulo NUM_REQ. ptr must be below NUM_REQ.
module fifo_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   winner
);

    logic [PTR_W-1:0]   idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot;

    // rot[k] is the request k positions after ptr, idx[k] its real producer index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [PTR_W:0] sum;
        assign sum     = {1'b0, ptr} + (PTR_W+1)'(gi);
        assign idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                                       : sum[PTR_W-1:0];
        assign rot[gi] = req[idx[gi]];
    end

    always_comb begin
        any    = |req;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of a synchronous FIFO write port.
// Optional per-producer grant counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 8,
    parameter  int BURST_LEN = 4,
    localparam int PTR_W     = clog2(NUM_REQ),
    localparam int CNT_W     = clog2(BURST_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.slave   bus,
    output logic               busy,
    output logic [PTR_W-1:0]   owner
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]  stat_cnt
`endif
);

    arb_state_t       state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] owner_reg, owner_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             busy_reg, busy_next;

    logic               pick_any;
    logic [PTR_W-1:0]   pick_winner;
    logic [NUM_REQ-1:0] gnt_w;
    logic [DATA_W-1:0]  masked [NUM_REQ];
    logic [DATA_W-1:0]  data_w;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            beat_cnt_reg <= beat_cnt_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any && !bus.full) begin
                    owner_next    = pick_winner;
                    beat_cnt_next = CNT_W'(1);
                    if (BURST_LEN == 1) begin
                        ptr_next = ptr_inc(pick_winner);
                    end else begin
                        state_next = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (bus.req[owner_reg]) begin
                    // A full cycle is a stall: the beat count holds and the burst stays open.
                    if (!bus.full) begin
                        if (beat_cnt_reg < CNT_W'(BURST_LEN)) begin
                            beat_cnt_next = beat_cnt_reg + 1'b1;
                        end
                        if (beat_cnt_reg == CNT_W'(BURST_LEN - 1)) begin
                            state_next = ST_IDLE;
                            ptr_next   = ptr_inc(owner_reg);
                        end
                    end
                end else begin
                    state_next = ST_IDLE;
                    ptr_next   = ptr_inc(owner_reg);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next == ST_BURST);
    end

    // Grants are decoded straight from the current state so the FIFO write is zero-latency.
    always_comb begin
        gnt_w = '0;
        if (rst_n && !bus.full) begin
            case (state_reg)
                ST_IDLE:  if (pick_any)            gnt_w[pick_winner] = 1'b1;
                ST_BURST: if (bus.req[owner_reg])  gnt_w[owner_reg]   = 1'b1;
                default:  gnt_w = '0;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
        assign masked[gi] = bus.req_data[gi*DATA_W +: DATA_W] & {DATA_W{gnt_w[gi]}};
    end

    always_comb begin
        data_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            data_w = data_w | masked[k];
        end
    end

    assign bus.gnt     = gnt_w;
    assign bus.we_enb  = |gnt_w;
    assign bus.data_in = data_w;
    assign busy        = busy_reg;
    assign owner       = owner_reg;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_reg [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_reg[gi] <= '0;
            end else if (stat_clr) begin
                stat_reg[gi] <= '0;
            end else if (gnt_w[gi] && (stat_reg[gi] != {STAT_W{1'b1}})) begin
                stat_reg[gi] <= stat_reg[gi] + 1'b1;
            end
        end
        assign stat_cnt[gi*STAT_W +: STAT_W] = stat_reg[gi];
    end
`endif

endmodule
